ext_addr_router: RTL and testbench
==================================

# ext_addr_router

Parametrised single-master, N-slave address router for the external OBI bus of the test harness. It generalises the static external address-map tables into a live routing block. Behaviour it adds:
- priority resolution of overlapping rules;
- an internal error slave for unmapped addresses;
- tracking of outstanding transactions, so responses return in order;
- a saturating counter of unmapped accesses.

It sits between the MCU external master port and the external slaves (slow memories, serial link, peripheral bus).

## Interface
Parameters:
- NSLAVE, 3, number of downstream slave ports (1..16)
- NRULES, 3, number of address rules
- ADDR_RULES, all-zero, addr_map_rule_t [NRULES-1:0] array (idx, start_addr, end_addr); idx selects the slave port
- MAX_OUTSTANDING, 4, maximum accepted-but-unanswered requests (1..15)
- ERR_RDATA, 32'hBADC0DE5, rdata returned by the error slave

Ports:
- clk_i  in  1  clock; all state on the rising edge
- rst_ni  in  1  reset, synchronous, active-low
- m_req_i  in  1  master request
- m_gnt_o  out  1  master grant
- m_addr_i  in  32  request address
- m_we_i  in  1  write enable
- m_be_i  in  4  byte enables
- m_wdata_i  in  32  write data
- m_rvalid_o  out  1  response valid
- m_rdata_o  out  32  response data
- m_err_o  out  1  response came from the error slave
- s_req_o  out  NSLAVE  one-hot request to the selected slave
- s_gnt_i  in  NSLAVE  slave grants
- s_addr_o, s_we_o, s_be_o, s_wdata_o  out  32/1/4/32  broadcast copies of the master fields
- s_rvalid_i  in  NSLAVE  slave response valids
- s_rdata_i  in  NSLAVE*32  slave read data; slave k occupies bits [32k+31:32k]
- unmapped_cnt_o  out  16  saturating count of accepted unmapped requests

## Operation
Decode (combinational, every cycle):
- A rule matches when start_addr <= m_addr_i < end_addr (unsigned, 32-bit; end is exclusive).
- Overlapping matches are resolved by the lowest rule array index.
- If no rule matches, or the winning rule has idx >= NSLAVE, the request targets the virtual error port, id NSLAVE.
- Target id width: $clog2(NSLAVE+1).

State:
- out_cnt: 0..MAX_OUTSTANDING.
- cur_tgt: target id of the in-flight transactions.
- err_pend: error slave has a response pending.
- unmapped_cnt: 16 bits.

Issue rule (blocking):
- A request may issue only if out_cnt == 0, or if decoded target == cur_tgt and out_cnt < MAX_OUTSTANDING.
- Otherwise s_req_o = 0 and m_gnt_o = 0 until out_cnt drains to 0.
- This guarantees in-order responses without reorder buffers.

Issuing to a real slave k:
- s_req_o[k] = m_req_i.
- m_gnt_o = s_gnt_i[k].

Issuing to the error port:
- No s_req_o bit is raised.
- m_gnt_o = 1 immediately.
- Response one cycle later: m_rvalid_o = 1, m_rdata_o = ERR_RDATA, m_err_o = 1.
- Writes are dropped.

On accept (m_req_i & m_gnt_o):
- cur_tgt <= decoded target.
- out_cnt increments.

Response routing:
- If cur_tgt < NSLAVE: m_rvalid_o = s_rvalid_i[cur_tgt] & (out_cnt != 0), m_rdata_o = the selected slice, m_err_o = 0.
- Each response decrements out_cnt.
- An accept and a response in the same cycle leave out_cnt unchanged.
- s_rvalid_i from a slave other than cur_tgt, or any response when out_cnt == 0, is ignored: no m_rvalid_o and no counter change.

Unmapped counter:
- unmapped_cnt increments on each accepted error-port request.
- It saturates at 16'hFFFF.

Reset (rst_ni low at a clock edge):
- out_cnt = 0, cur_tgt = 0, err_pend = 0, unmapped_cnt = 0.
- Outputs read as: m_gnt_o = 0, s_req_o = 0, m_rvalid_o = 0, m_err_o = 0, m_rdata_o = 0, unmapped_cnt_o = 0.
- Reset mid-transaction abandons all in-flight responses. Later stray s_rvalid_i are ignored because out_cnt == 0.

## Timing
- Request path is combinational, 0-cycle: m_req_i/m_addr_i to s_req_o; s_gnt_i to m_gnt_o.
- Slave response path is combinational, 0-cycle: s_rvalid_i/s_rdata_i to m_rvalid_o/m_rdata_o.
- Error-port response arrives exactly 1 cycle after the accept. Back-to-back error accepts give back-to-back rvalids.
- A stalled request (target switch) issues the cycle after the final response brings out_cnt to 0. It is never issued in the same cycle as that response.
- unmapped_cnt_o is registered and updates the cycle after the accept.

## Test plan
- **Overlap priority.** Rules {0:[0x2000,0x2400), 1:[0x2000,0x2400), 2:[0x12000,0x12200)}; read 0x2100 → only s_req_o[0] asserted. Read 0x12010 → s_req_o[2] asserted. The s_rdata_i slice of the answering slave appears on m_rdata_o.
- **Unmapped access.** Read 0x9000 → m_gnt_o = 1 in the same cycle; the next cycle gives m_rvalid_o = 1, m_rdata_o = 0xBADC0DE5, m_err_o = 1. unmapped_cnt_o = 1. No s_req_o bit is raised.
- **Outstanding limit.** MAX_OUTSTANDING = 4; slave 0 grants every cycle but withholds rvalid → 4 accepts, then m_gnt_o = 0. One rvalid → exactly one further accept.
- **Target switch stall.** Two reads outstanding to slave 0, then a request to slave 2 → s_req_o = 0 until both slave-0 responses return. It issues on the following cycle, and responses arrive in order.
- **Simultaneous events and stray responses.** Accept and response in the same cycle → out_cnt holds its value. Pulse s_rvalid_i[1] while cur_tgt = 0 → no m_rvalid_o.
- **Reset and saturation.**
  - Reset with 3 transactions outstanding → all outputs 0; a later s_rvalid_i is ignored.
  - Force 65 536 unmapped accepts → unmapped_cnt_o holds at 0xFFFF.

Source files
------------

// File: rtl/ext_addr_router.sv
// Single-master, N-slave OBI address router with prioritised rule decode,
// an internal error slave, in-order outstanding tracking and an unmapped counter.
package ext_addr_router_pkg;
    typedef struct packed {
        logic [31:0] idx;
        logic [31:0] start_addr;
        logic [31:0] end_addr;
    } addr_map_rule_t;
endpackage

module ext_addr_router
    import ext_addr_router_pkg::*;
#(
    parameter int unsigned                  NSLAVE          = 3,
    parameter int unsigned                  NRULES          = 3,
    parameter addr_map_rule_t [NRULES-1:0]  ADDR_RULES      = '0,
    parameter int unsigned                  MAX_OUTSTANDING = 4,
    parameter logic [31:0]                  ERR_RDATA       = 32'hBADC0DE5
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 m_req_i,
    output logic                 m_gnt_o,
    input  logic [31:0]          m_addr_i,
    input  logic                 m_we_i,
    input  logic [3:0]           m_be_i,
    input  logic [31:0]          m_wdata_i,
    output logic                 m_rvalid_o,
    output logic [31:0]          m_rdata_o,
    output logic                 m_err_o,
    output logic [NSLAVE-1:0]    s_req_o,
    input  logic [NSLAVE-1:0]    s_gnt_i,
    output logic [31:0]          s_addr_o,
    output logic                 s_we_o,
    output logic [3:0]           s_be_o,
    output logic [31:0]          s_wdata_o,
    input  logic [NSLAVE-1:0]    s_rvalid_i,
    input  logic [NSLAVE*32-1:0] s_rdata_i,
    output logic [15:0]          unmapped_cnt_o
);

    localparam int unsigned   TW     = $clog2(NSLAVE + 1);
    localparam int unsigned   CW     = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [TW-1:0] ERR_ID = TW'(NSLAVE);

    logic [CW-1:0] out_cnt;
    logic [TW-1:0] cur_tgt;
    logic          err_pend;
    logic [15:0]   unmapped_cnt;

    logic [TW-1:0] dec_tgt;
    logic          tgt_is_err;
    logic          can_issue;
    logic          sel_gnt;
    logic          accept;
    logic          slv_rvalid;
    logic [31:0]   slv_rdata;
    logic          cur_is_err;
    logic          resp;

    assign s_addr_o  = m_addr_i;
    assign s_we_o    = m_we_i;
    assign s_be_o    = m_be_i;
    assign s_wdata_o = m_wdata_i;

    // Scan from the highest rule down so the lowest-indexed match wins.
    always_comb begin
        dec_tgt = ERR_ID;
        for (int r = int'(NRULES) - 1; r >= 0; r--) begin
            if ((m_addr_i >= ADDR_RULES[r].start_addr) && (m_addr_i < ADDR_RULES[r].end_addr)) begin
                dec_tgt = (ADDR_RULES[r].idx < 32'(NSLAVE)) ? TW'(ADDR_RULES[r].idx) : ERR_ID;
            end
        end
    end

    assign tgt_is_err = (dec_tgt == ERR_ID);

    // Only one target may have transactions in flight, which keeps responses in order.
    assign can_issue = (out_cnt == '0) ||
                       ((dec_tgt == cur_tgt) && (out_cnt < CW'(MAX_OUTSTANDING)));

    always_comb begin
        s_req_o = '0;
        sel_gnt = 1'b0;
        for (int k = 0; k < int'(NSLAVE); k++) begin
            if (dec_tgt == TW'(k)) begin
                s_req_o[k] = m_req_i & can_issue;
                sel_gnt    = s_gnt_i[k];
            end
        end
    end

    assign m_gnt_o = m_req_i & can_issue & (tgt_is_err | sel_gnt);
    assign accept  = m_req_i & m_gnt_o;

    always_comb begin
        slv_rvalid = 1'b0;
        slv_rdata  = '0;
        for (int k = 0; k < int'(NSLAVE); k++) begin
            if (cur_tgt == TW'(k)) begin
                slv_rvalid = s_rvalid_i[k];
                slv_rdata  = s_rdata_i[32*k +: 32];
            end
        end
    end

    assign cur_is_err = (cur_tgt == ERR_ID);
    assign resp       = cur_is_err ? err_pend : (slv_rvalid & (out_cnt != '0));

    assign m_rvalid_o     = resp;
    assign m_err_o        = resp & cur_is_err;
    assign m_rdata_o      = !resp ? 32'h0 : (cur_is_err ? ERR_RDATA : slv_rdata);
    assign unmapped_cnt_o = unmapped_cnt;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            out_cnt      <= '0;
            cur_tgt      <= '0;
            err_pend     <= 1'b0;
            unmapped_cnt <= '0;
        end else begin
            if (accept) begin
                cur_tgt <= dec_tgt;
            end
            if (accept && !resp) begin
                out_cnt <= out_cnt + CW'(1);
            end else if (!accept && resp) begin
                out_cnt <= out_cnt - CW'(1);
            end
            err_pend <= accept & tgt_is_err;
            if (accept && tgt_is_err && (unmapped_cnt != 16'hFFFF)) begin
                unmapped_cnt <= unmapped_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_ext_addr_router.sv
// Directed self-checking bench for ext_addr_router: decode priority, error slave,
// outstanding limit, target-switch stall, stray responses, reset and saturation.
module tb_ext_addr_router;
    import ext_addr_router_pkg::*;

    localparam addr_map_rule_t RULE0 = '{idx: 32'd0, start_addr: 32'h0000_2000, end_addr: 32'h0000_2400};
    localparam addr_map_rule_t RULE1 = '{idx: 32'd1, start_addr: 32'h0000_2000, end_addr: 32'h0000_2400};
    localparam addr_map_rule_t RULE2 = '{idx: 32'd2, start_addr: 32'h0001_2000, end_addr: 32'h0001_2200};
    localparam addr_map_rule_t [2:0] RULES = {RULE2, RULE1, RULE0};

    localparam logic [31:0] RD0 = 32'hAAAA_0000;
    localparam logic [31:0] RD1 = 32'h1111_0001;
    localparam logic [31:0] RD2 = 32'h2222_0002;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        m_req;
    logic        m_gnt;
    logic [31:0] m_addr;
    logic        m_we;
    logic [3:0]  m_be;
    logic [31:0] m_wdata;
    logic        m_rvalid;
    logic [31:0] m_rdata;
    logic        m_err;
    logic [2:0]  s_req;
    logic [2:0]  s_gnt;
    logic [31:0] s_addr;
    logic        s_we;
    logic [3:0]  s_be;
    logic [31:0] s_wdata;
    logic [2:0]  s_rvalid;
    logic [95:0] s_rdata;
    logic [15:0] unmapped_cnt;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    ext_addr_router #(
        .NSLAVE(3),
        .NRULES(3),
        .ADDR_RULES(RULES),
        .MAX_OUTSTANDING(4),
        .ERR_RDATA(32'hBADC0DE5)
    ) dut (
        .clk_i(clk),
        .rst_ni(rst_n),
        .m_req_i(m_req),
        .m_gnt_o(m_gnt),
        .m_addr_i(m_addr),
        .m_we_i(m_we),
        .m_be_i(m_be),
        .m_wdata_i(m_wdata),
        .m_rvalid_o(m_rvalid),
        .m_rdata_o(m_rdata),
        .m_err_o(m_err),
        .s_req_o(s_req),
        .s_gnt_i(s_gnt),
        .s_addr_o(s_addr),
        .s_we_o(s_we),
        .s_be_o(s_be),
        .s_wdata_o(s_wdata),
        .s_rvalid_i(s_rvalid),
        .s_rdata_i(s_rdata),
        .unmapped_cnt_o(unmapped_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Inputs change 1 time unit after an edge; outputs are sampled 1 unit later.
    task automatic applyStimulus(input logic req, input logic [31:0] addr,
                                 input logic [2:0] gnt, input logic [2:0] rvalid);
        m_req    = req;
        m_addr   = addr;
        s_gnt    = gnt;
        s_rvalid = rvalid;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        m_req   = 1'b0;
        m_addr  = '0;
        m_we    = 1'b0;
        m_be    = 4'hF;
        m_wdata = 32'h0;
        s_gnt   = '0;
        s_rvalid = '0;
        s_rdata = {RD2, RD1, RD0};

        tick();
        tick();
        applyStimulus(1'b0, 32'h0, 3'b000, 3'b000);
        checkOutput("reset_gnt", m_gnt, 0);
        checkOutput("reset_sreq", s_req, 0);
        checkOutput("reset_rvalid", m_rvalid, 0);
        checkOutput("reset_err", m_err, 0);
        checkOutput("reset_rdata", m_rdata, 0);
        checkOutput("reset_ucnt", unmapped_cnt, 0);
        rst_n = 1'b1;
        tick();

        // Overlapping rules 0 and 1: rule 0 must win
        m_we = 1'b1; m_wdata = 32'hCAFE_F00D; m_be = 4'h3;
        applyStimulus(1'b1, 32'h2100, 3'b000, 3'b000);
        checkOutput("ovl_sreq", s_req, 3'b001);
        checkOutput("ovl_gnt_wait", m_gnt, 0);
        checkOutput("bcast_addr", s_addr, 32'h2100);
        checkOutput("bcast_we_be", {s_we, s_be}, 5'b1_0011);
        checkOutput("bcast_wdata", s_wdata, 32'hCAFE_F00D);
        m_we = 1'b0; m_be = 4'hF;
        applyStimulus(1'b1, 32'h2100, 3'b001, 3'b000);
        checkOutput("ovl_gnt", m_gnt, 1);
        tick();
        applyStimulus(1'b0, 32'h0, 3'b000, 3'b001);
        checkOutput("ovl_rvalid", m_rvalid, 1);
        checkOutput("ovl_rdata", m_rdata, RD0);
        checkOutput("ovl_err", m_err, 0);
        tick();

        // Rule 2 target
        applyStimulus(1'b1, 32'h12010, 3'b100, 3'b000);
        checkOutput("r2_sreq", s_req, 3'b100);
        checkOutput("r2_gnt", m_gnt, 1);
        tick();
        applyStimulus(1'b0, 32'h0, 3'b000, 3'b100);
        checkOutput("r2_rvalid", m_rvalid, 1);
        checkOutput("r2_rdata", m_rdata, RD2);
        tick();

        // Unmapped read goes to the error slave
        applyStimulus(1'b1, 32'h9000, 3'b000, 3'b000);
        checkOutput("unm_gnt", m_gnt, 1);
        checkOutput("unm_sreq", s_req, 0);
        tick();
        applyStimulus(1'b0, 32'h0, 3'b000, 3'b000);
        checkOutput("unm_rvalid", m_rvalid, 1);
        checkOutput("unm_rdata", m_rdata, 32'hBADC0DE5);
        checkOutput("unm_err", m_err, 1);
        checkOutput("unm_ucnt", unmapped_cnt, 1);
        tick();
        applyStimulus(1'b0, 32'h0, 3'b000, 3'b000);
        checkOutput("unm_single_rsp", m_rvalid, 0);

        // End address is exclusive (combinational only, no accept)
        applyStimulus(1'b1, 32'h23FC, 3'b000, 3'b000);
        checkOutput("edge_in_sreq", s_req, 3'b001);
        applyStimulus(1'b1, 32'h2400, 3'b000, 3'b000);
        checkOutput("edge_out_sreq", s_req, 0);
        checkOutput("edge_out_gnt", m_gnt, 1);
        applyStimulus(1'b0, 32'h0, 3'b000, 3'b000);
        tick();

        // Outstanding limit of 4
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 32'h2000, 3'b001, 3'b000);
            checkOutput($sformatf("lim_gnt_%0d", i), m_gnt, (i < 4) ? 1 : 0);
            tick();
        end
        applyStimulus(1'b1, 32'h2000, 3'b001, 3'b001);
        checkOutput("lim_rsp_rvalid", m_rvalid, 1);
        checkOutput("lim_rsp_gnt", m_gnt, 0);
        tick();
        applyStimulus(1'b1, 32'h2000, 3'b001, 3'b000);
        checkOutput("lim_one_more", m_gnt, 1);
        tick();
        applyStimulus(1'b1, 32'h2000, 3'b001, 3'b000);
        checkOutput("lim_full_again", m_gnt, 0);
        applyStimulus(1'b0, 32'h0, 3'b000, 3'b001);
        repeat (4) tick();
        applyStimulus(1'b0, 32'h0, 3'b000, 3'b001);
        checkOutput("lim_drained", m_rvalid, 0);

        // Accept and response in the same cycle, plus a stray response
        applyStimulus(1'b1, 32'h2000, 3'b001, 3'b000);
        tick();
        tick();
        applyStimulus(1'b1, 32'h2000, 3'b001, 3'b001);
        checkOutput("sim_rvalid", m_rvalid, 1);
        checkOutput("sim_gnt", m_gnt, 1);
        tick();
        applyStimulus(1'b0, 32'h0, 3'b000, 3'b010);
        checkOutput("stray_rvalid", m_rvalid, 0);
        tick();
        applyStimulus(1'b0, 32'h0, 3'b000, 3'b001);
        checkOutput("sim_rsp_a", m_rvalid, 1);
        tick();
        applyStimulus(1'b0, 32'h0, 3'b000, 3'b001);
        checkOutput("sim_rsp_b", m_rvalid, 1);
        tick();
        applyStimulus(1'b0, 32'h0, 3'b000, 3'b001);
        checkOutput("sim_cnt_zero", m_rvalid, 0);
        tick();

        // Target switch stalls until slave 0 drains
        applyStimulus(1'b1, 32'h2000, 3'b001, 3'b000);
        tick();
        tick();
        applyStimulus(1'b1, 32'h12000, 3'b100, 3'b000);
        checkOutput("sw_stall_sreq", s_req, 0);
        checkOutput("sw_stall_gnt", m_gnt, 0);
        tick();
        applyStimulus(1'b1, 32'h12000, 3'b100, 3'b001);
        checkOutput("sw_rsp1", m_rvalid, 1);
        checkOutput("sw_rsp1_sreq", s_req, 0);
        tick();
        applyStimulus(1'b1, 32'h12000, 3'b100, 3'b001);
        checkOutput("sw_rsp2", m_rvalid, 1);
        checkOutput("sw_rsp2_rdata", m_rdata, RD0);
        checkOutput("sw_rsp2_sreq", s_req, 0);
        checkOutput("sw_rsp2_gnt", m_gnt, 0);
        tick();
        applyStimulus(1'b1, 32'h12000, 3'b100, 3'b000);
        checkOutput("sw_issue_sreq", s_req, 3'b100);
        checkOutput("sw_issue_gnt", m_gnt, 1);
        tick();
        applyStimulus(1'b0, 32'h0, 3'b000, 3'b100);
        checkOutput("sw_rsp3_rdata", m_rdata, RD2);
        tick();

        // Reset with three transactions outstanding
        applyStimulus(1'b1, 32'h2000, 3'b001, 3'b000);
        repeat (3) tick();
        applyStimulus(1'b0, 32'h0, 3'b000, 3'b000);
        checkOutput("pre_rst_ucnt", unmapped_cnt, 1);
        rst_n = 1'b0;
        tick();
        applyStimulus(1'b0, 32'h0, 3'b000, 3'b000);
        checkOutput("rst2_gnt", m_gnt, 0);
        checkOutput("rst2_sreq", s_req, 0);
        checkOutput("rst2_rvalid", m_rvalid, 0);
        checkOutput("rst2_ucnt", unmapped_cnt, 0);
        rst_n = 1'b1;
        tick();
        applyStimulus(1'b0, 32'h0, 3'b000, 3'b001);
        checkOutput("rst2_stray_rvalid", m_rvalid, 0);
        checkOutput("rst2_stray_rdata", m_rdata, 0);
        tick();

        // Saturating unmapped counter
        applyStimulus(1'b1, 32'h9000, 3'b000, 3'b000);
        repeat (65534) tick();
        checkOutput("sat_fffe", unmapped_cnt, 16'hFFFE);
        checkOutput("sat_b2b_rvalid", m_rvalid, 1);
        checkOutput("sat_b2b_err", m_err, 1);
        tick();
        checkOutput("sat_ffff", unmapped_cnt, 16'hFFFF);
        repeat (3) tick();
        checkOutput("sat_hold", unmapped_cnt, 16'hFFFF);
        applyStimulus(1'b0, 32'h0, 3'b000, 3'b000);
        tick();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
